// File: rtl/uart_bus_slave.sv
// Memory-mapped 8N1 UART responder: TXD/RXD/CON word registers, level IRQ.
// Define UART_RX_FIFO_EN for a 4-entry RX FIFO instead of a single holding register.
`timescale 1ns/1ps
module uart_bus_slave #(
    parameter int          CLKS_PER_BIT = 10417,
    parameter logic [31:0] BASE_ADDR    = 32'h40000018
) (
    input  logic        reset,
    input  logic        clk,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [29:0] A_TXD = BASE_ADDR[31:2];
    localparam logic [29:0] A_RXD = A_TXD + 30'd1;
    localparam logic [29:0] A_CON = A_TXD + 30'd2;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic w_sel_txd, w_sel_rxd, w_sel_con;
    logic w_wr_txd, w_wr_con, w_rd_rxd, w_rd_con;
    logic w_unused;

    assign w_sel_txd = (addr[31:2] == A_TXD);
    assign w_sel_rxd = (addr[31:2] == A_RXD);
    assign w_sel_con = (addr[31:2] == A_CON);
    assign w_wr_txd  = wr & w_sel_txd;
    assign w_wr_con  = wr & w_sel_con;
    assign w_rd_rxd  = rd & w_sel_rxd;
    assign w_rd_con  = rd & w_sel_con;
    assign w_unused  = ^{addr[1:0], wdata[31:8]};

    state_t          r_tx_st;
    logic [CW-1:0]   r_tx_cnt;
    logic [2:0]      r_tx_bit;
    logic [7:0]      r_tx_sh;
    logic [7:0]      r_txd;
    logic            r_tx_busy;
    logic            r_uart_tx;
    logic            w_tx_end;
    logic            w_tx_done_set;

    assign w_tx_end      = (r_tx_cnt == C_LAST);
    assign w_tx_done_set = (r_tx_st == S_STOP) && w_tx_end;
    assign uart_tx       = r_uart_tx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_st   <= S_IDLE;
            r_tx_cnt  <= '0;
            r_tx_bit  <= '0;
            r_tx_sh   <= '0;
            r_txd     <= '0;
            r_tx_busy <= 1'b0;
            r_uart_tx <= 1'b1;
        end else begin
            unique case (r_tx_st)
                S_IDLE: begin
                    if (w_wr_txd) begin
                        r_txd     <= wdata[7:0];
                        r_tx_sh   <= wdata[7:0];
                        r_tx_busy <= 1'b1;
                        r_tx_cnt  <= '0;
                        r_uart_tx <= 1'b0;
                        r_tx_st   <= S_START;
                    end
                end
                S_START: begin
                    if (w_tx_end) begin
                        r_tx_cnt  <= '0;
                        r_tx_bit  <= '0;
                        r_uart_tx <= r_tx_sh[0];
                        r_tx_sh   <= r_tx_sh >> 1;
                        r_tx_st   <= S_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_tx_end) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_uart_tx <= 1'b1;
                            r_tx_st   <= S_STOP;
                        end else begin
                            r_tx_bit  <= r_tx_bit + 3'd1;
                            r_uart_tx <= r_tx_sh[0];
                            r_tx_sh   <= r_tx_sh >> 1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_tx_end) begin
                        r_tx_cnt  <= '0;
                        r_tx_busy <= 1'b0;
                        r_tx_st   <= S_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    logic            r_rx_s1, r_rx_s2, r_rx_d;
    state_t          r_rx_st;
    logic [CW-1:0]   r_rx_cnt;
    logic [2:0]      r_rx_bit;
    logic [7:0]      r_rx_sh;
    logic            w_rx_fall;
    logic            w_rx_end;
    logic            w_rx_stop_smp;
    logic            w_rx_deliver;
    logic            w_rx_ferr;

    assign w_rx_fall     = r_rx_d & ~r_rx_s2;
    assign w_rx_end      = (r_rx_cnt == C_LAST);
    assign w_rx_stop_smp = (r_rx_st == S_STOP) && w_rx_end;
    assign w_rx_deliver  = w_rx_stop_smp & r_rx_s2;
    assign w_rx_ferr     = w_rx_stop_smp & ~r_rx_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_s1  <= 1'b1;
            r_rx_s2  <= 1'b1;
            r_rx_d   <= 1'b1;
            r_rx_st  <= S_IDLE;
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            r_rx_sh  <= '0;
        end else begin
            r_rx_s1 <= uart_rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
            unique case (r_rx_st)
                S_IDLE: begin
                    r_rx_cnt <= '0;
                    if (w_rx_fall) r_rx_st <= S_START;
                end
                S_START: begin
                    // mid-start check rejects short glitches
                    if (r_rx_cnt == C_HALF) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        r_rx_st  <= r_rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_rx_end) begin
                        r_rx_cnt <= '0;
                        r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                        r_rx_bit <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7) r_rx_st <= S_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_rx_end) begin
                        r_rx_cnt <= '0;
                        r_rx_st  <= S_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    logic       w_rx_valid;
    logic       w_rx_valid_nxt;
    logic [7:0] w_rx_head;
    logic       w_ovr_set;

`ifdef UART_RX_FIFO_EN
    logic [7:0] r_fifo [4];
    logic [1:0] r_wp, r_rp;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic       w_pop, w_push, w_full;

    assign w_rx_valid     = (r_cnt != 3'd0);
    assign w_full         = r_cnt[2];
    assign w_rx_head      = r_fifo[r_rp];
    assign w_pop          = w_rd_rxd & w_rx_valid;
    // a pop on the same edge frees the slot for the incoming byte
    assign w_push         = w_rx_deliver & (~w_full | w_pop);
    assign w_ovr_set      = w_rx_deliver & w_full & ~w_pop;
    assign w_cnt_nxt      = r_cnt + {2'b0, w_push} - {2'b0, w_pop};
    assign w_rx_valid_nxt = (w_cnt_nxt != 3'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) r_fifo[i] <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wp] <= r_rx_sh;
                r_wp         <= r_wp + 2'd1;
            end
            if (w_pop) r_rp <= r_rp + 2'd1;
            r_cnt <= w_cnt_nxt;
        end
    end
`else
    logic [7:0] r_rxd;
    logic       r_rx_valid;

    assign w_rx_valid     = r_rx_valid;
    assign w_rx_head      = r_rxd;
    assign w_ovr_set      = w_rx_deliver & r_rx_valid & ~w_rd_rxd;
    assign w_rx_valid_nxt = w_rx_deliver | (r_rx_valid & ~w_rd_rxd);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rxd      <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            if (w_rx_deliver) r_rxd <= r_rx_sh;
            r_rx_valid <= w_rx_valid_nxt;
        end
    end
`endif

    logic [1:0] r_en;
    logic       r_tx_done, r_ovr, r_ferr, r_irq;
    logic [1:0] w_en_nxt;
    logic       w_tx_done_nxt, w_ovr_nxt, w_ferr_nxt;
    logic [31:0] w_con;

    // set beats the read-clear when both land on one edge
    assign w_en_nxt      = w_wr_con ? wdata[1:0] : r_en;
    assign w_tx_done_nxt = w_tx_done_set | (r_tx_done & ~w_rd_con);
    assign w_ovr_nxt     = w_ovr_set | (r_ovr & ~w_rd_con);
    assign w_ferr_nxt    = w_rx_ferr | (r_ferr & ~w_rd_con);
    assign w_con         = {25'b0, r_ferr, r_ovr, r_tx_busy,
                            w_rx_valid, r_tx_done, r_en};
    assign irq           = r_irq;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_en      <= '0;
            r_tx_done <= 1'b0;
            r_ovr     <= 1'b0;
            r_ferr    <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_en      <= w_en_nxt;
            r_tx_done <= w_tx_done_nxt;
            r_ovr     <= w_ovr_nxt;
            r_ferr    <= w_ferr_nxt;
            r_irq     <= (w_en_nxt[0] & w_tx_done_nxt)
                       | (w_en_nxt[1] & w_rx_valid_nxt);
        end
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (w_sel_txd)      rdata = {24'b0, r_txd};
            else if (w_sel_rxd) rdata = {24'b0, w_rx_head};
            else if (w_sel_con) rdata = w_con;
        end
    end
endmodule

// File: tb/tb_uart_bus_slave.sv
// Directed self-checking bench for uart_bus_slave at 16 clocks per bit.
// Covers reset, TX framing, TX busy, RX, RX errors and overrun (UART_RX_FIFO_EN aware).
`timescale 1ns/1ps
module tb_uart_bus_slave;
    localparam int          CPB  = 16;
    localparam logic [31:0] BASE = 32'h40000018;
    localparam logic [31:0] TXD  = BASE;
    localparam logic [31:0] RXD  = BASE + 32'd4;
    localparam logic [31:0] CON  = BASE + 32'd8;

    logic        reset, clk, rd, wr, uart_rx, uart_tx, irq;
    logic [31:0] addr, wdata, rdata;
    int          n_run, n_fail;
    logic [31:0] v;
    logic [9:0]  frame;

    uart_bus_slave #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE)) dut (
        .reset(reset), .clk(clk), .rd(rd), .wr(wr), .addr(addr),
        .wdata(wdata), .rdata(rdata), .uart_rx(uart_rx),
        .uart_tx(uart_tx), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        rd = 1'b1; addr = a;
        #1 d = rdata;
        @(negedge clk);
        rd = 1'b0; addr = '0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        n_run = 0; n_fail = 0;
        reset = 1'b0; rd = 1'b0; wr = 1'b0; uart_rx = 1'b1;
        addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check("post_reset_tx", {31'b0, uart_tx}, 32'd1);

        // 1: reset mid-frame
        bus_write(TXD, 32'h00);
        repeat (20) @(negedge clk);
        check("midframe_tx_low", {31'b0, uart_tx}, 32'd0);
        #3 reset = 1'b0;
        #1 check("async_reset_tx", {31'b0, uart_tx}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        bus_read(CON, v);
        check("reset_con", v, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'd0);
        bus_read(TXD, v);
        check("reset_txd", v, 32'h0);

        // 2: transmit 0xA5 with exact bit timing
        bus_write(CON, 32'h1);
        bus_write(TXD, 32'hA5);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int b = 0; b < 10; b++) begin
            check($sformatf("txA5_b%0d_first", b), {31'b0, uart_tx},
                  {31'b0, frame[b]});
            repeat (CPB - 1) @(negedge clk);
            check($sformatf("txA5_b%0d_last", b), {31'b0, uart_tx},
                  {31'b0, frame[b]});
            @(negedge clk);
        end
        check("tx_done_irq", {31'b0, irq}, 32'd1);
        addr = CON;
        #1 check("rdata_no_rd", rdata, 32'h0);
        addr = '0;
        bus_read(BASE + 32'd12, v);
        check("read_nomatch", v, 32'h0);
        bus_read(CON, v);
        check("con_after_tx", v, 32'h05);
        bus_read(CON, v);
        check("con_cleared", v, 32'h01);
        check("irq_cleared", {31'b0, irq}, 32'd0);

        // 3: write while busy is ignored
        bus_write(TXD, 32'h11);
        bus_write(TXD, 32'h22);
        bus_read(TXD, v);
        check("txd_busy_keep", v, 32'h11);
        repeat (4) @(negedge clk);
        frame = {1'b1, 8'h11, 1'b0};
        for (int b = 0; b < 10; b++) begin
            check($sformatf("tx11_b%0d", b), {31'b0, uart_tx},
                  {31'b0, frame[b]});
            repeat (CPB) @(negedge clk);
        end
        check("tx11_idle", {31'b0, uart_tx}, 32'd1);
        bus_read(CON, v);
        check("tx11_con", v, 32'h05);

        // 4: receive 0x3C
        bus_write(CON, 32'h2);
        send_byte(8'h3C, 1'b1);
        check("rx_irq", {31'b0, irq}, 32'd1);
        bus_read(CON, v);
        check("rx_con_valid", v, 32'h0A);
        bus_read(RXD, v);
        check("rx_data", v, 32'h3C);
        bus_read(CON, v);
        check("rx_con_popped", v, 32'h02);
        check("rx_irq_clear", {31'b0, irq}, 32'd0);

        // 5: framing error, then a glitch
        bus_write(CON, 32'h0);
        send_byte(8'h55, 1'b0);
        bus_read(CON, v);
        check("frame_err", v, 32'h40);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        bus_read(CON, v);
        check("glitch_none", v, 32'h00);

        // 6: overrun
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        bus_read(CON, v);
        check("ovr_con", v, 32'h28);
`ifdef UART_RX_FIFO_EN
        for (int i = 1; i <= 4; i++) begin
            bus_read(RXD, v);
            check($sformatf("fifo_rd%0d", i), v, 32'(i));
        end
`else
        bus_read(RXD, v);
        check("ovr_rxd", v, 32'h05);
`endif
        bus_read(CON, v);
        check("ovr_con_after", v, 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
